regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file, the successor to the single-write, two-read CPU regfile. Adds configurable width, depth, read and write port counts, and write-to-read bypass across all write ports. Also adds a busy-bit scoreboard for pipeline hazard detection and a sequential clear sweep in place of a full-array reset. It sits between decode (read, issue) and writeback (write) in the pipelined core.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of registers; power of 2, at least 2
NRD, 2, number of read ports
NWR, 2, number of write ports
ZERO_REG, 1, if 1, register 0 reads as 0, is never written and is never busy
AW, $clog2(NREG), address width (derived, not overridable)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
flush  in  1  sync request to clear all registers and busy bits
ready  out  1  high when the array is valid and accepting traffic
rd_addr  in  NRD*AW  packed read addresses; port i uses slice i
rd_data  out  NRD*XLEN  packed read data, combinational
rd_busy  out  NRD  per read port, source register is pending a producer
wr_en  in  NWR  per-port write enables
wr_addr  in  NWR*AW  packed write addresses
wr_data  in  NWR*XLEN  packed write data
issue_en  in  1  mark issue_addr busy (new in-flight producer)
issue_addr  in  AW  destination of the issued instruction

Behaviour:
- Reset (rst=0, async):
  - state=CLEAR, sweep counter=0, ready=0, all busy bits=0.
  - The data array is not reset directly.
- FSM states: CLEAR, RUN.
  - CLEAR: writes 0 to array[counter] each cycle, then counter increments.
  - After the write of entry NREG-1: state becomes RUN and ready=1 on the following edge.
  - ready first goes high NREG cycles after the first clk edge with rst=1.
  - RUN with flush=1: next state CLEAR, counter=0, all busy bits cleared, ready=0 next cycle.
  - flush during CLEAR restarts the counter at 0.
- While ready=0:
  - rd_data all 0 and rd_busy all 0.
  - wr_en and issue_en are ignored.
- Writes (RUN only): on each edge, every port with wr_en[j]=1 writes wr_data[j] to array[wr_addr[j]].
  - Multiple ports to the same address in one cycle: the highest-index port wins.
  - If ZERO_REG=1, writes to address 0 are dropped.
- Reads: combinational, zero latency.
  - If ZERO_REG=1 and addr=0: output 0.
  - Else if any write port j has wr_en[j]=1 and wr_addr[j]=addr: output the wr_data of the highest such j (transparent bypass).
  - Else: output array[addr].
- Scoreboard (RUN only), per edge:
  - wr_en[j] clears busy[wr_addr[j]].
  - issue_en sets busy[issue_addr].
  - If issue and write hit the same address in the same cycle, set wins (newer producer).
  - If ZERO_REG=1, busy[0] is forced to 0.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (any active write to rd_addr[i] this cycle), because the bypass already supplies the value.
  - Issue in the same cycle does not affect rd_busy until the next cycle.
- With ZERO_REG=0, register 0 behaves like any other register.
- Reset mid-sweep or mid-traffic: immediately returns to CLEAR as above. Pending writes in that cycle are lost.
- Synthesis: array in flops or LUT-RAM, with no async reset on the array.

Test Plan:
- Reset release, NREG=32 -> ready=0 for exactly 32 edges, then 1; all 32 registers then read 0 and rd_busy=0.
- RUN: write x5=0xDEADBEEF via port 0 while reading rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally; the next cycle without a write still reads 0xDEADBEEF.
- Ports 0 and 1 both write x7, with 0x11111111 and 0x22222222 -> bypass and the stored value are both 0x22222222. Any write to x0 -> x0 reads 0.
- issue_en with x9 -> next cycle rd_busy=1 when reading x9. A writeback to x9 in a later cycle -> rd_busy=0 in that cycle via bypass, and busy is cleared after the edge. Simultaneous issue and write on x9 -> busy stays 1.
- flush in RUN after filling registers with nonzero values -> ready=0 next cycle, then NREG cycles of sweep. Reads return 0 during the sweep, and all registers read 0 with no busy bits after the sweep. Writes attempted during the sweep have no effect.
- Assert rst low mid-sweep (counter=10) -> asynchronous return to CLEAR. After release, the full NREG-cycle sweep repeats from 0.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port integer register file with
//                write-to-read bypass across all write ports, a busy-bit
//                scoreboard for hazard detection, and a sequential clear
//                sweep that replaces a full-array reset.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1         rising-edge clock
//    rst        in   1         asynchronous, active-low reset
//    flush      in   1         request to clear all registers and busy bits
//    ready      out  1         array valid and accepting traffic
//    rd_addr    in   NRD*AW    packed read addresses, port i = slice i
//    rd_data    out  NRD*XLEN  packed combinational read data
//    rd_busy    out  NRD       source register still waiting on a producer
//    wr_en      in   NWR       per-port write enables
//    wr_addr    in   NWR*AW    packed write addresses
//    wr_data    in   NWR*XLEN  packed write data
//    issue_en   in   1         mark issue_addr busy
//    issue_addr in   AW        destination of the issued instruction
// ============================================================================
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr
);

  localparam logic [0:0]    c_st_clear = 1'b0;
  localparam logic [0:0]    c_st_run   = 1'b1;
  localparam logic [AW-1:0] c_last     = AW'(NREG - 1);

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_run;
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [XLEN-1:0] r_mem [NREG];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_clear;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. The sweep counter selects the entry cleared this cycle;
  // a flush at any time restarts the sweep from entry 0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_clear: begin
        if (flush) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_last) begin
          w_state_nxt = c_st_run;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      c_st_run: begin
        if (flush) begin
          w_state_nxt = c_st_clear;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = c_st_clear;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_run = (r_state == c_st_run);
    ready = w_run;
  end

  // --------------------------------------------------------------------------
  // Busy scoreboard. Writebacks clear first, then issue sets, so a new
  // producer issued in the same cycle as an older one retires stays pending.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = r_busy;
    if (!w_run || flush) begin
      w_busy_nxt = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j]) begin
          w_busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (issue_en) begin
        w_busy_nxt[issue_addr] = 1'b1;
      end
    end
    if (ZERO_REG) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Storage. Each entry resolves its own write: the sweep writes zero to the
  // entry under the counter, otherwise the highest-index matching write port
  // wins. The array itself carries no reset so it can map onto LUT-RAM.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NREG; k++) begin : g_reg
      logic            w_we;
      logic [XLEN-1:0] w_wd;

      always_comb begin
        w_we = 1'b0;
        w_wd = '0;
        if (!w_run) begin
          w_we = (r_cnt == AW'(k));
        end else if (!(ZERO_REG && (k == 0))) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(k))) begin
              w_we = 1'b1;
              w_wd = wr_data[j*XLEN +: XLEN];
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (w_we) begin
          r_mem[k] <= w_wd;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read ports with transparent bypass from every write port.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic            w_hit;
      logic [XLEN-1:0] w_byp;

      assign w_addr = rd_addr[i*AW +: AW];

      always_comb begin
        w_hit = 1'b0;
        w_byp = '0;
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == w_addr)) begin
            w_hit = 1'b1;
            w_byp = wr_data[j*XLEN +: XLEN];
          end
        end
      end

      always_comb begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
        if (w_run) begin
          if (ZERO_REG && (w_addr == '0)) begin
            rd_data[i*XLEN +: XLEN] = '0;
          end else if (w_hit) begin
            rd_data[i*XLEN +: XLEN] = w_byp;
          end else begin
            rd_data[i*XLEN +: XLEN] = r_mem[w_addr];
          end
          // A write landing this cycle already supplies the value.
          rd_busy[i] = r_busy[w_addr] & ~w_hit;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp (default parameters).
//                A behavioural model of the register file tracks contents,
//                busy bits and the clear sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_addr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];
  bit              m_ready;
  int              m_sweep;

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input int i);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = rd_addr[i*AW +: AW];
    if (!m_ready || a == 0) return '0;
    v = m_mem[a];
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_busy(input int i);
    logic [AW-1:0] a;
    a = rd_addr[i*AW +: AW];
    if (!m_ready) return 1'b0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_sweep = 0;
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
  endtask

  task automatic model_edge();
    logic [AW-1:0] a;
    if (!rst) begin
      model_reset();
    end else if (!m_ready) begin
      m_mem[m_sweep] = '0;
      if (flush) begin
        m_sweep = 0;
      end else begin
        m_sweep++;
        if (m_sweep == NREG) begin
          m_ready = 1'b1;
          m_sweep = 0;
        end
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        a = wr_addr[j*AW +: AW];
        if (wr_en[j] && a != 0) m_mem[a] = wr_data[j*XLEN +: XLEN];
      end
      if (flush) begin
        model_reset();
      end else begin
        for (int j = 0; j < NWR; j++)
          if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
        if (issue_en) m_busy[issue_addr] = 1'b1;
        m_busy[0] = 1'b0;
      end
    end
  endtask

  // Compare all outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    @(negedge clk);
    chk("ready", {31'b0, ready}, {31'b0, m_ready});
    for (int i = 0; i < NRD; i++) begin
      chk($sformatf("rd_data[%0d]", i), rd_data[i*XLEN +: XLEN], exp_data(i));
      chk($sformatf("rd_busy[%0d]", i), {31'b0, rd_busy[i]}, {31'b0, exp_busy(i)});
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    issue_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic randomize_inputs(input int flush_pct);
    wr_en      = NWR'($urandom_range(0, 3));
    issue_en   = 1'($urandom_range(0, 1));
    issue_addr = AW'($urandom_range(0, 7));
    flush      = ($urandom_range(0, 99) < flush_pct);
    for (int j = 0; j < NWR; j++) begin
      wr_addr[j*AW +: AW]   = AW'($urandom_range(0, 7));
      wr_data[j*XLEN +: XLEN] = $urandom;
    end
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
  endtask

  task automatic wait_ready();
    int n = 0;
    idle();
    while (!ready && n < 40) begin
      cycle();
      n++;
    end
    chk("wait_ready", {31'b0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; issue_addr = '0;
    for (int r = 0; r < NREG; r++) m_mem[r] = 'x;
    model_reset();
    repeat (3) cycle();

    // Reset release: exactly NREG edges of sweep before ready rises.
    rst = 1'b1;
    for (int k = 0; k < NREG; k++) begin
      chk("ready_in_sweep", {31'b0, ready}, 32'd0);
      cycle();
    end
    chk("ready_after_sweep", {31'b0, ready}, 32'd1);

    // Every register reads zero, none busy.
    for (int r = 0; r < NREG; r += NRD) begin
      rd_addr = {AW'(r + 1), AW'(r)};
      cycle();
    end

    // Bypass then stored value for x5.
    rd_addr = {AW'(0), AW'(5)};
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'hDEADBEEF};
    #1 chk("bypass_x5", rd_data[31:0], 32'hDEADBEEF);
    cycle();
    idle();
    #1 chk("stored_x5", rd_data[31:0], 32'hDEADBEEF);
    cycle();

    // Two ports to x7: port 1 wins.
    rd_addr = {AW'(7), AW'(7)};
    wr_en = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {32'h22222222, 32'h11111111};
    #1 chk("bypass_x7", rd_data[31:0], 32'h22222222);
    cycle();
    idle();
    #1 chk("stored_x7", rd_data[63:32], 32'h22222222);
    cycle();

    // x0 is hardwired.
    rd_addr = {AW'(0), AW'(0)};
    wr_en = 2'b11; wr_addr = {AW'(0), AW'(0)}; wr_data = {32'hA5A5A5A5, 32'h5A5A5A5A};
    #1 chk("x0_bypass", rd_data[31:0], 32'h0);
    cycle();
    idle();
    #1 chk("x0_stored", rd_data[63:32], 32'h0);
    cycle();

    // Scoreboard on x9.
    rd_addr = {AW'(9), AW'(9)};
    issue_en = 1'b1; issue_addr = AW'(9);
    #1 chk("busy_same_cycle", {30'b0, rd_busy}, 32'd0);
    cycle();
    idle();
    #1 chk("busy_after_issue", {30'b0, rd_busy}, 32'd3);
    cycle();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h00000099};
    #1 chk("busy_wb_bypass", {30'b0, rd_busy}, 32'd0);
    chk("data_wb_bypass", rd_data[31:0], 32'h00000099);
    cycle();
    idle();
    #1 chk("busy_cleared", {30'b0, rd_busy}, 32'd0);
    cycle();
    issue_en = 1'b1; issue_addr = AW'(9);
    cycle();
    issue_en = 1'b1; wr_en = 2'b10; wr_addr = {AW'(9), AW'(0)}; wr_data = {32'h77, 32'h0};
    cycle();
    idle();
    #1 chk("busy_set_wins", {30'b0, rd_busy}, 32'd3);
    cycle();

    // Randomised traffic with occasional flushes.
    repeat (400) begin
      randomize_inputs(2);
      cycle();
    end

    // Fill with nonzero values, flush, and attempt writes during the sweep.
    wait_ready();
    for (int r = 1; r < NREG; r++) begin
      wr_en = 2'b01; wr_addr = {AW'(0), AW'(r)}; wr_data = {32'h0, $urandom | 32'h1};
      issue_en = 1'b1; issue_addr = AW'(r);
      cycle();
    end
    idle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      randomize_inputs(0);
      flush = 1'b0;
      chk("ready_flush_sweep", {31'b0, ready}, 32'd0);
      cycle();
    end
    idle();
    chk("ready_after_flush", {31'b0, ready}, 32'd1);
    for (int r = 0; r < NREG; r += NRD) begin
      rd_addr = {AW'(r + 1), AW'(r)};
      cycle();
    end

    // Asynchronous reset mid-sweep (counter at 10).
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();
    rst = 1'b0;
    model_reset();
    #1 chk("ready_in_reset", {31'b0, ready}, 32'd0);
    repeat (2) cycle();
    rst = 1'b1;
    for (int k = 0; k < NREG; k++) begin
      chk("ready_resweep", {31'b0, ready}, 32'd0);
      cycle();
    end
    chk("ready_after_resweep", {31'b0, ready}, 32'd1);
    for (int r = 0; r < NREG; r += NRD) begin
      rd_addr = {AW'(r + 1), AW'(r)};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
